// File: rtl/desired_drive_gen2_pkg.sv
// Shared defaults and helpers for the pipelined desired-drive calculator.
// Imported by desired_drive_gen2 and curr_slew_lim.
package desired_drive_pkg;

    localparam int DEF_TORQUE_MIN = 'h380;
    localparam int DEF_CAD_MIN    = 2;
    localparam int DEF_CAD_OFF    = 32;
    localparam int DEF_INCL_OFF   = 256;
    localparam int DEF_OUT_SHIFT  = 14;
    localparam int DEF_SLEW_UP    = 64;
    localparam int DEF_SLEW_DN    = 256;

    // Full-precision product width: torque * incline_lim * cad_factor * setting.
    function automatic int prod_width(input int torque_w, input int incl_sat_w,
                                      input int cad_w, input int set_w);
        return torque_w + (incl_sat_w - 1) + (cad_w + 1) + set_w;
    endfunction

    function automatic int sat_signed(input int v, input int w);
        int hi;
        int lo;
        hi = (1 << (w - 1)) - 1;
        lo = -(1 << (w - 1));
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/desired_drive_gen2_if.sv
// Sample-in / target-out bus of desired_drive_gen2.
// in_vld qualifies one sample per cycle with no ready (the pipeline never stalls);
// out_vld pulses for exactly one cycle whenever target_curr and sat have been updated.
interface desired_drive_gen2_if #(
    parameter int TORQUE_W = 12,
    parameter int CAD_W    = 5,
    parameter int INCL_W   = 13,
    parameter int SET_W    = 2,
    parameter int CURR_W   = 12
);
    logic                in_vld;
    logic [TORQUE_W-1:0] avg_torque;
    logic [CAD_W-1:0]    cadence_vec;
    logic [INCL_W-1:0]   incline;
    logic [SET_W-1:0]    setting;
    logic                assist_en;
    logic [CURR_W-1:0]   target_curr;
    logic                out_vld;
    logic                sat;

    modport master (
        output in_vld, avg_torque, cadence_vec, incline, setting, assist_en,
        input  target_curr, out_vld, sat
    );

    modport slave (
        input  in_vld, avg_torque, cadence_vec, incline, setting, assist_en,
        output target_curr, out_vld, sat
    );
endinterface

// File: rtl/desired_drive_gen2_curr_slew_lim.sv
// Slew-rate limited target current register: moves cur toward raw by at most
// SLEW_UP (rising) or SLEW_DN (falling) on each upd cycle.
module curr_slew_lim
    import desired_drive_pkg::*;
#(
    parameter int CURR_W  = 12,
    parameter int SLEW_UP = DEF_SLEW_UP,
    parameter int SLEW_DN = DEF_SLEW_DN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              upd,
    input  logic [CURR_W-1:0] raw,
    output logic [CURR_W-1:0] cur
);
    logic [CURR_W-1:0] step_up;
    logic [CURR_W-1:0] step_dn;
    logic [CURR_W-1:0] cur_d;

    always_comb begin
        step_up = raw - cur;
        step_dn = cur - raw;
        cur_d   = cur;
        if (raw > cur)
            cur_d = cur + ((step_up > CURR_W'(SLEW_UP)) ? CURR_W'(SLEW_UP) : step_up);
        else if (raw < cur)
            cur_d = cur - ((step_dn > CURR_W'(SLEW_DN)) ? CURR_W'(SLEW_DN) : step_dn);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)      cur <= '0;
        else if (upd) cur <= cur_d;
    end
endmodule

// File: rtl/desired_drive_gen2.sv
// Pipelined desired-drive calculator: torque/cadence/incline/assist -> motor target current.
// Define DESIRED_DRIVE_SLEW_EN to slew-limit target_curr through curr_slew_lim.
module desired_drive_gen2
    import desired_drive_pkg::*;
#(
    parameter int TORQUE_W   = 12,
    parameter int CAD_W      = 5,
    parameter int INCL_W     = 13,
    parameter int INCL_SAT_W = 10,
    parameter int SET_W      = 2,
    parameter int CURR_W     = 12,
    parameter int TORQUE_MIN = DEF_TORQUE_MIN,
    parameter int CAD_MIN    = DEF_CAD_MIN,
    parameter int CAD_OFF    = DEF_CAD_OFF,
    parameter int INCL_OFF   = DEF_INCL_OFF,
    parameter int OUT_SHIFT  = DEF_OUT_SHIFT,
    parameter int SLEW_UP    = DEF_SLEW_UP,
    parameter int SLEW_DN    = DEF_SLEW_DN
) (
    input logic                 clk,
    input logic                 rst,
    desired_drive_gen2_if.slave bus
);
    localparam int LIM_W   = INCL_SAT_W - 1;
    localparam int LIM_MAX = (1 << LIM_W) - 1;
    localparam int CADF_W  = CAD_W + 1;
    localparam int PA_W    = TORQUE_W + LIM_W;
    localparam int PB_W    = CADF_W + SET_W;
    localparam int P       = prod_width(TORQUE_W, INCL_SAT_W, CAD_W, SET_W);

    int                  incl_sat;
    int                  incl_fac;
    logic [LIM_W-1:0]    incl_lim_d;
    logic [TORQUE_W-1:0] torque_d;
    logic [CADF_W-1:0]   cad_d;

    logic                s1_vld, s1_en;
    logic [TORQUE_W-1:0] s1_torque;
    logic [LIM_W-1:0]    s1_incl;
    logic [CADF_W-1:0]   s1_cad;
    logic [SET_W-1:0]    s1_set;
    logic                s2_vld, s2_en;
    logic [PA_W-1:0]     s2_a;
    logic [PB_W-1:0]     s2_b;
    logic                s3_vld, s3_en;
    logic [P-1:0]        s3_prod;
    logic                s4_vld, s4_sat;
    logic [CURR_W-1:0]   s4_raw;
    logic [CURR_W-1:0]   raw_d;
    logic                sat_d;

    logic [CURR_W-1:0]   tgt_q;
    logic                out_vld_q;
    logic                sat_q;

    // Stage 1 operand conditioning; only the incline path is signed.
    always_comb begin
        incl_sat   = sat_signed(int'(signed'(bus.incline)), INCL_SAT_W);
        incl_fac   = incl_sat + INCL_OFF;
        incl_lim_d = LIM_W'(incl_fac);
        if (incl_fac < 0)            incl_lim_d = '0;
        else if (incl_fac > LIM_MAX) incl_lim_d = LIM_W'(LIM_MAX);
        torque_d = (bus.avg_torque < TORQUE_W'(TORQUE_MIN)) ? '0
                 : bus.avg_torque - TORQUE_W'(TORQUE_MIN);
        cad_d    = (bus.cadence_vec < CAD_W'(CAD_MIN)) ? '0
                 : CADF_W'(bus.cadence_vec) + CADF_W'(CAD_OFF);
    end

    always_comb begin
        raw_d = '0;
        sat_d = 1'b0;
        if (s3_en) begin
            if ((s3_prod >> (OUT_SHIFT + CURR_W)) != '0) begin
                raw_d = '1;
                sat_d = 1'b1;
            end else begin
                raw_d = s3_prod[OUT_SHIFT +: CURR_W];
            end
        end
    end

    // Data registers load every cycle; the valid bit rides alongside.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_vld <= 1'b0; s1_en <= 1'b0; s1_torque <= '0; s1_incl <= '0;
            s1_cad <= '0;   s1_set <= '0;
            s2_vld <= 1'b0; s2_en <= 1'b0; s2_a <= '0; s2_b <= '0;
            s3_vld <= 1'b0; s3_en <= 1'b0; s3_prod <= '0;
            s4_vld <= 1'b0; s4_sat <= 1'b0; s4_raw <= '0;
            out_vld_q <= 1'b0; sat_q <= 1'b0;
        end else begin
            s1_vld    <= bus.in_vld;
            s1_en     <= bus.assist_en;
            s1_torque <= torque_d;
            s1_incl   <= incl_lim_d;
            s1_cad    <= cad_d;
            s1_set    <= bus.setting;
            s2_vld    <= s1_vld;
            s2_en     <= s1_en;
            s2_a      <= PA_W'(s1_torque) * PA_W'(s1_incl);
            s2_b      <= PB_W'(s1_cad) * PB_W'(s1_set);
            s3_vld    <= s2_vld;
            s3_en     <= s2_en;
            s3_prod   <= P'(s2_a) * P'(s2_b);
            s4_vld    <= s3_vld;
            s4_raw    <= raw_d;
            s4_sat    <= sat_d;
            out_vld_q <= s4_vld;
            if (s4_vld) sat_q <= s4_sat;
        end
    end

`ifdef DESIRED_DRIVE_SLEW_EN
    curr_slew_lim #(
        .CURR_W  (CURR_W),
        .SLEW_UP (SLEW_UP),
        .SLEW_DN (SLEW_DN)
    ) u_slew (
        .clk (clk),
        .rst (rst),
        .upd (s4_vld),
        .raw (s4_raw),
        .cur (tgt_q)
    );
`else
    // Slew limits only matter when the limiter is built.
    logic [CURR_W-1:0] unused_slew;
    assign unused_slew = CURR_W'(SLEW_UP) ^ CURR_W'(SLEW_DN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         tgt_q <= '0;
        else if (s4_vld) tgt_q <= s4_raw;
    end
`endif

    assign bus.target_curr = tgt_q;
    assign bus.out_vld     = out_vld_q;
    assign bus.sat         = sat_q;
endmodule

// File: tb/tb_desired_drive_gen2.sv
// Directed bench for desired_drive_gen2 (default build, or slew build with DESIRED_DRIVE_SLEW_EN).
module tb_desired_drive_gen2;
    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    desired_drive_gen2_if dd_if ();

    desired_drive_gen2 dut (
        .clk (clk),
        .rst (rst),
        .bus (dd_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef DESIRED_DRIVE_SLEW_EN
    localparam int COLD_EXP = 'h040;
`else
    localparam int COLD_EXP = 'h540;
`endif

    // Pipeline slots: A B C D E F gap G gap I H (hand-computed targets).
    localparam int NSLOT = 11;
    int s_vld [NSLOT] = '{1, 1, 1, 1, 1, 1, 0, 1, 0, 1, 1};
    int s_trq [NSLOT] = '{'h780, 'h480, 'h381, 'h380, 'h780, 'hB80, 0, 'h480, 0, 'h780, 'hB80};
    int s_cad [NSLOT] = '{10, 2, 31, 31, 10, 31, 0, 2, 0, 10, 31};
    int s_inc [NSLOT] = '{0, 0, 300, 255, -128, 255, 0, 100, 0, -4096, 255};
    int s_set [NSLOT] = '{2, 1, 3, 3, 1, 1, 0, 1, 0, 2, 2};
    int s_exp [NSLOT] = '{'h540, 'h088, 'h005, 0, 'h150, 'hFB8, 0, 'h0BD, 0, 0, 'hFFF};
    int s_sat [NSLOT] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    logic [12:0] exp_q[$];

    task automatic drive(input logic vld, input int torque, input int cad, input int incl,
                         input int set, input logic en);
        dd_if.in_vld      = vld;
        dd_if.avg_torque  = 12'(torque);
        dd_if.cadence_vec = 5'(cad);
        dd_if.incline     = 13'(incl);
        dd_if.setting     = 2'(set);
        dd_if.assist_en   = en;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic run_one(input string tag, input int torque, input int cad, input int incl,
                           input int set, input logic en, input int exp_c, input logic exp_s);
        drive(1'b1, torque, cad, incl, set, en);
        tick();
        dd_if.in_vld = 1'b0;
        repeat (3) tick();
        chk({tag, " early"}, 32'(dd_if.out_vld), 0);
        tick();
        chk({tag, " vld"},  32'(dd_if.out_vld), 1);
        chk({tag, " curr"}, 32'(dd_if.target_curr), exp_c);
        chk({tag, " sat"},  32'(dd_if.sat), 32'(exp_s));
        tick();
        chk({tag, " pulse"}, 32'(dd_if.out_vld), 0);
        chk({tag, " hold"},  32'(dd_if.target_curr), exp_c);
    endtask

    initial begin
        logic [12:0] got;
        int          exp_v;
        int          k;
        int          exp_c;

        drive(1'b0, 0, 0, 0, 0, 1'b0);
        rst = 1'b1;
        #12;
        chk("reset curr", 32'(dd_if.target_curr), 0);
        chk("reset vld",  32'(dd_if.out_vld), 0);
        chk("reset sat",  32'(dd_if.sat), 0);
        tick();
        tick();
        rst = 1'b0;
        tick();

`ifndef DESIRED_DRIVE_SLEW_EN
        run_one("nominal",   'h780, 10, 0, 2, 1'b1, 'h540, 1'b0);
        run_one("cad_min",   'h780, 1, 0, 2, 1'b1, 0, 1'b0);
        run_one("nominal2",  'h780, 10, 0, 2, 1'b1, 'h540, 1'b0);
        run_one("torq_min",  'h37F, 10, 0, 2, 1'b1, 0, 1'b0);
        run_one("nominal3",  'h780, 10, 0, 2, 1'b1, 'h540, 1'b0);
        run_one("incl_neg",  'h780, 10, -300, 2, 1'b1, 0, 1'b0);
        run_one("nominal4",  'h780, 10, 0, 2, 1'b1, 'h540, 1'b0);
        run_one("set_off",   'h780, 10, 0, 0, 1'b1, 0, 1'b0);
        run_one("saturate",  'hFFF, 31, 'h0FFF, 3, 1'b1, 'hFFF, 1'b1);
        run_one("assist_off",'hFFF, 31, 'h0FFF, 3, 1'b0, 0, 1'b0);

        for (int cyc = 0; cyc < NSLOT + 5; cyc++) begin
            if (cyc < NSLOT) begin
                drive(s_vld[cyc] != 0, s_trq[cyc], s_cad[cyc], s_inc[cyc], s_set[cyc], 1'b1);
                if (s_vld[cyc] != 0) exp_q.push_back({1'(s_sat[cyc]), 12'(s_exp[cyc])});
            end else begin
                dd_if.in_vld = 1'b0;
            end
            tick();
            exp_v = (cyc >= 4 && cyc - 4 < NSLOT) ? s_vld[cyc - 4] : 0;
            chk($sformatf("pipe c%0d vld", cyc), 32'(dd_if.out_vld), exp_v);
            if (exp_v != 0 && exp_q.size() > 0) begin
                got = exp_q.pop_front();
                chk($sformatf("pipe s%0d curr", cyc - 4), 32'(dd_if.target_curr), 32'(got[11:0]));
                chk($sformatf("pipe s%0d sat", cyc - 4),  32'(dd_if.sat), 32'(got[12]));
            end
        end
        chk("pipe drained", exp_q.size(), 0);
`else
        // 22 nominal samples ramp up by 64, then 7 with assist off ramp down by 256.
        for (int cyc = 0; cyc < 29 + 5; cyc++) begin
            if (cyc < 29) drive(1'b1, 'h780, 10, 0, 2, cyc < 22);
            else          dd_if.in_vld = 1'b0;
            tick();
            k = cyc - 4;
            if (k >= 0 && k < 29) begin
                if (k < 22) exp_c = ((k + 1) * 64 > 'h540) ? 'h540 : (k + 1) * 64;
                else        exp_c = ('h540 - (k - 21) * 256 < 0) ? 0 : 'h540 - (k - 21) * 256;
                chk($sformatf("slew k%0d vld", k),  32'(dd_if.out_vld), 1);
                chk($sformatf("slew k%0d curr", k), 32'(dd_if.target_curr), exp_c);
                chk($sformatf("slew k%0d sat", k),  32'(dd_if.sat), 0);
            end else begin
                chk($sformatf("slew c%0d idle", cyc), 32'(dd_if.out_vld), 0);
            end
        end
`endif

        // Reset with a sample two stages deep; it must vanish without a pulse.
        run_one("pre_reset", 'h780, 10, 0, 2, 1'b1, COLD_EXP, 1'b0);
        drive(1'b1, 'h780, 10, 0, 2, 1'b1);
        tick();
        dd_if.in_vld = 1'b0;
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst curr", 32'(dd_if.target_curr), 0);
        chk("mid_rst vld",  32'(dd_if.out_vld), 0);
        chk("mid_rst sat",  32'(dd_if.sat), 0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk($sformatf("post_rst c%0d vld", i),  32'(dd_if.out_vld), 0);
            chk($sformatf("post_rst c%0d curr", i), 32'(dd_if.target_curr), 0);
        end
        run_one("cold", 'h780, 10, 0, 2, 1'b1, COLD_EXP, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/desired_drive_gen2.md
Name: desired_drive_gen2

Overview:
- Parametrised, pipelined successor of the e-bike desired-drive calculator.
- Converts averaged pedal torque, cadence, incline and assist setting into a motor target current.
- Adds a valid-tagged fixed-latency pipeline, a registered saturation flag, an assist-enable gate and an optional slew-rate limiter.
- Sits between the sensor-conditioning blocks and the motor current PI loop.

Parameters:
- TORQUE_W, 12, avg_torque width.
- CAD_W, 5, cadence_vec width.
- INCL_W, 13, signed incline width.
- INCL_SAT_W, 10, signed width incline is saturated to.
- SET_W, 2, assist setting width.
- CURR_W, 12, target current width.
- TORQUE_MIN, 12'h380, torque dead-zone offset.
- CAD_MIN, 2, cadence below which assist is zero.
- CAD_OFF, 32, cadence offset added.
- INCL_OFF, 256, incline offset added.
- OUT_SHIFT, 14, product LSBs discarded.
- SLEW_UP, 64, max increase per valid sample.
- SLEW_DN, 256, max decrease per valid sample.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- in_vld, input, 1, sample valid.
- avg_torque, input, TORQUE_W, unsigned averaged torque.
- cadence_vec, input, CAD_W, unsigned cadence.
- incline, input, INCL_W, two's-complement incline.
- setting, input, SET_W, assist level (0 = off).
- assist_en, input, 1, sampled with in_vld; 0 forces a raw target of 0.
- target_curr, output, CURR_W, registered target current.
- out_vld, output, 1, one-cycle pulse when target_curr has been updated.
- sat, output, 1, product overflowed CURR_W for the last output sample.

Behaviour:
- Reset (async, rst=1): every pipeline register, valid bit, target_curr, out_vld and sat go to 0 immediately. A sample in flight is discarded. No output pulse follows reset release.
- Pipeline has no backpressure. Data registers load every cycle; a valid bit shifts alongside the data. Latency is exactly 4: in_vld at edge N gives out_vld at edge N+4. Back-to-back samples are accepted every cycle.
- S1 (incline):
  - Saturate incline to a signed INCL_SAT_W value: clamp to [-2^(INCL_SAT_W-1), 2^(INCL_SAT_W-1)-1].
  - Form incline_factor = sign-extended saturated value + INCL_OFF.
  - incline_lim = 0 if incline_factor < 0; 2^(INCL_SAT_W-1)-1 if incline_factor exceeds that; otherwise incline_factor. Width is INCL_SAT_W-1.
- S1 (cadence): cad_factor = 0 if cadence_vec < CAD_MIN, else cadence_vec + CAD_OFF. Width is CAD_W+1.
- S1 (torque): torque_pos = 0 if avg_torque < TORQUE_MIN, else avg_torque - TORQUE_MIN.
- S1 (gating): setting and assist_en are registered alongside.
- S2: prod_a = torque_pos * incline_lim. prod_b = cad_factor * setting.
- S3: prod = prod_a * prod_b. Width P = TORQUE_W + INCL_SAT_W - 1 + CAD_W + 1 + SET_W (29 at defaults).
- S4 raw value:
  - If assist_en = 0, raw = 0 and sat = 0.
  - Else if any prod bit at or above OUT_SHIFT + CURR_W is set, raw = all ones and sat = 1.
  - Else raw = prod[OUT_SHIFT+CURR_W-1:OUT_SHIFT] and sat = 0.
- S4 register update: target_curr and sat update only on a valid S4 cycle. Otherwise they hold and out_vld = 0.
- All arithmetic is unsigned except incline saturation. No intermediate truncation.

Optional Feature:
- Macro DESIRED_DRIVE_SLEW_EN.
- Defined: on each valid S4 cycle,
  - if raw > target_curr, target_curr += min(raw - target_curr, SLEW_UP);
  - if raw < target_curr, target_curr -= min(target_curr - raw, SLEW_DN);
  - if equal, hold.
  - sat still reflects raw. Latency unchanged.
- Undefined: target_curr = raw on each valid S4 cycle; SLEW_UP and SLEW_DN are unused.

Decomposition:
- Package desired_drive_pkg holds:
  - default constants (TORQUE_MIN, CAD_MIN, CAD_OFF, INCL_OFF, OUT_SHIFT, SLEW_UP, SLEW_DN);
  - a localparam-style function computing P;
  - a signed-saturate function.
- Sub-module curr_slew_lim (CURR_W, SLEW_UP, SLEW_DN parameters; clk, rst, upd, raw, cur) is instantiated only under the macro.

Test Plan:
- Nominal: avg_torque=0x780, cadence_vec=10, incline=0, setting=2, assist_en=1, slew off -> out_vld 4 cycles later, target_curr=0x540, sat=0.
- Saturation: avg_torque=0xFFF, cadence_vec=31, incline=13'h0FFF, setting=3 -> target_curr=0xFFF, sat=1.
- Zero cases -> each gives target_curr=0:
  - cadence_vec=1;
  - avg_torque=0x37F;
  - incline=-300 (clamps factor to 0);
  - setting=0;
  - assist_en=0.
- Pipelining: 6 distinct back-to-back in_vld samples -> 6 consecutive out_vld pulses, each result matching its input in order; an in_vld gap produces the matching out_vld gap.
- Slew (macro on): hold nominal input -> target_curr steps 64, 128, … and reaches 0x540 on the 21st sample. Then drop assist_en -> decreases by 256 per sample to 0.
- Reset mid-operation: assert rst 2 cycles after in_vld -> outputs 0 immediately, no out_vld after rst release; next sample behaves as from cold.
